md_scheduler: RTL and testbench

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_scheduler_pkg.sv | 50 +++++
 rtl/md_scheduler_arith.sv | 72 +++++++
 rtl/md_scheduler.sv | 153 +++++++++++++++
 tb/tb_md_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/md_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// md_scheduler_pkg
//
// Purpose:
//   Shared multiply/divide definitions. The controller, the hazard logic and
//   the MD scheduler all import this package, so they agree on three things:
//   the md_op encoding, the default latencies and the scheduler state
//   encoding.
//
// Contents:
//   md_op_e             - 3-bit MD operation encoding (6 and 7 are reserved)
//   md_state_e          - scheduler FSM state encoding (IDLE / BUSY)
//   MD_MULT_CYCLES_DEF  - default busy cycles for mult/multu
//   MD_DIV_CYCLES_DEF   - default busy cycles for div/divu
//   md_is_long_op()     - true for the multi-cycle ops (mult/multu/div/divu)
//   md_is_div_op()      - true for div/divu
// ---------------------------------------------------------------------------
package md_scheduler_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // The multi-cycle ops are the ones that occupy the unit and later
    // commit their result to HI/LO.
    function automatic logic md_is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_scheduler_arith.sv
// ---------------------------------------------------------------------------
// md_arith
//
// Purpose:
//   Purely combinational MD datapath. It produces the 64-bit {HI,LO} result
//   for mult, multu, div and divu. The scheduler latches this result in the
//   issue cycle, and the busy period afterwards only models latency.
//
// Ports:
//   md_op       in  [2:0]  operation (md_op_e encoding)
//   src_a       in  [31:0] rs operand (dividend for divides)
//   src_b       in  [31:0] rt operand (divisor for divides)
//   result      out [63:0] {HI,LO}: product, or {remainder,quotient}
//   div_by_zero out        divide op with src_b == 0; result is then 0
// ---------------------------------------------------------------------------
module md_arith
    import md_scheduler_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0]        a_sext;
    logic [63:0]        b_sext;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;

    // Signed multiply is done as a 64x64 product of sign-extended operands.
    // The low 64 bits of that product are the exact signed 64-bit result.
    // Verilog's signed / and % truncate toward zero, and the remainder takes
    // the sign of the dividend, which is the MIPS behaviour. A zero divisor
    // never reaches the divider, so that case cannot produce undefined values.
    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        a_sext      = {{32{src_a[31]}}, src_a};
        b_sext      = {{32{src_b[31]}}, src_b};
        quo_s       = 32'sd0;
        rem_s       = 32'sd0;
        case (md_op_e'(md_op))
            MD_MULT: begin
                result = a_sext * b_sext;
            end
            MD_MULTU: begin
                result = {32'd0, src_a} * {32'd0, src_b};
            end
            MD_DIV: begin
                if (src_b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else begin
                    quo_s  = $signed(src_a) / $signed(src_b);
                    rem_s  = $signed(src_a) % $signed(src_b);
                    result = {rem_s, quo_s};
                end
            end
            MD_DIVU: begin
                if (src_b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else begin
                    result = {src_a % src_b, src_a / src_b};
                end
            end
            default: begin
                result = 64'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// ---------------------------------------------------------------------------
// md_scheduler
//
// Purpose:
//   Multi-cycle multiply/divide unit for the pipeline. It owns the HI/LO
//   architectural registers. A long op computes its result at issue, parks
//   it in a pending register, and stays busy for a fixed latency before it
//   commits to {HI,LO}. mthi/mtlo write at issue. While the unit is busy or
//   an op is issuing, any D-stage MD instruction is stalled.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu
//   DIV_CYCLES   busy cycles for div/divu
//
// Ports:
//   clk       in          clock, rising edge
//   reset     in          synchronous active-high reset
//   start     in          E-stage MD instruction issues this cycle
//   md_op     in  [2:0]   operation (md_op_e encoding)
//   src_a     in  [31:0]  E-stage rs value
//   src_b     in  [31:0]  E-stage rt value
//   d_is_md   in          D-stage instruction is an MD instruction
//   rd_sel    in          0 = read HI, 1 = read LO (mfhi/mflo)
//   rd_data   out [31:0]  selected HI/LO value (combinational)
//   busy      out         multi-cycle op in flight
//   stall_md  out         freeze PC, F/D and clear D/E
//   hi, lo    out [31:0]  architectural HI and LO
// ---------------------------------------------------------------------------
module md_scheduler
    import md_scheduler_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_is_md,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               busy_q,    busy_d;
    logic [31:0]        hi_q,      hi_d;
    logic [31:0]        lo_q,      lo_d;
    logic [63:0]        pending_q, pending_d;
    logic               pend_wr_q, pend_wr_d;

    logic [63:0]        arith_result;
    logic               arith_div_zero;

    md_arith u_arith (
        .md_op       (md_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (arith_result),
        .div_by_zero (arith_div_zero)
    );

    // Next-state logic.
    // In IDLE a long op captures its result and loads the down-counter with
    // its latency. The unit then stays busy for exactly that many cycles and
    // commits on the edge where the counter reads 1. A divide by zero still
    // spends its full latency, but pend_wr is cleared so that HI/LO keep
    // their old values. In BUSY, start is ignored altogether.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pending_d = pending_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (md_is_long_op(md_op)) begin
                        pending_d = arith_result;
                        pend_wr_d = ~arith_div_zero;
                        cnt_d     = md_is_div_op(md_op) ? CNT_W'(DIV_CYCLES)
                                                        : CNT_W'(MULT_CYCLES);
                        busy_d    = 1'b1;
                        state_d   = ST_BUSY;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = src_a;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pending_q[63:32];
                        lo_d = pending_q[31:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset takes priority over everything, including a
    // concurrent start and an op already in flight. An aborted op clears
    // pend_wr, so it can never commit later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pending_q <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pending_q <= pending_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // In the commit cycle, rd_data still shows the old HI/LO. This is safe
    // because stall_md holds any mfhi/mflo in D until busy drops.
    assign rd_data  = rd_sel ? lo_q : hi_q;
    assign busy     = busy_q;
    assign stall_md = d_is_md & (start | busy_q);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// ---------------------------------------------------------------------------
// tb_md_scheduler
//
// Directed test bench for md_scheduler. It drives hand-computed vectors and
// compares HI/LO, busy, stall_md and rd_data against fixed expected values.
// ---------------------------------------------------------------------------
module tb_md_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_is_md;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int totalCount = 0;
    int badCount   = 0;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_RSV6  = 3'd6;

    always #5 clk = ~clk;

    md_scheduler #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .d_is_md  (d_is_md),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic dmd, input logic rs);
        start   = st;
        md_op   = op;
        src_a   = a;
        src_b   = b;
        d_is_md = dmd;
        rd_sel  = rs;
        #1;
    endtask

    // Issue a long op, then follow its n busy cycles and check that
    // rd_data (LO) still shows preLo in the commit cycle.
    task automatic runLongOp(input string tag, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input int n, input logic [31:0] preLo);
        applyStimulus(1'b1, op, a, b, 1'b1, 1'b1);
        checkOutput({tag, "_stall_issue"}, 32'(stall_md), 32'd1);
        tick();
        applyStimulus(1'b0, op, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            checkOutput({tag, "_stall"}, 32'(stall_md), 32'd1);
            if (i == n - 1) begin
                checkOutput({tag, "_rd_precommit"}, rd_data, preLo);
            end
            tick();
        end
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
        checkOutput({tag, "_stall_done"}, 32'(stall_md), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, OP_MTHI, 32'hAAAA_5555, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_stall", 32'(stall_md), 32'd0);
        checkOutput("rst_rd", rd_data, 32'd0);

        $display("[TB] mult -3*5");
        runLongOp("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'd0);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFF1);

        $display("[TB] multu 0xFFFFFFFF*2");
        runLongOp("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFF1);
        checkOutput("multu_hi", hi, 32'h0000_0001);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFE);

        $display("[TB] div -7/2");
        runLongOp("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFE);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);

        $display("[TB] div 100/-7");
        runLongOp("div2", OP_DIV, 32'd100, 32'hFFFF_FFF9, 10, 32'hFFFF_FFFD);
        checkOutput("div2_hi", hi, 32'd2);
        checkOutput("div2_lo", lo, 32'hFFFF_FFF2);

        $display("[TB] mthi/mtlo then divu by zero");
        applyStimulus(1'b1, OP_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, OP_MTLO, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
        checkOutput("mthi_busy", 32'(busy), 32'd0);
        checkOutput("mthi_hi", hi, 32'h0000_1234);
        tick();
        applyStimulus(1'b1, OP_RSV6, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        checkOutput("mtlo_lo", lo, 32'h0000_5678);
        checkOutput("mfhi_rd", rd_data, 32'h0000_1234);
        tick();
        applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("rsv_busy", 32'(busy), 32'd0);
        checkOutput("rsv_hi", hi, 32'h0000_1234);
        checkOutput("rsv_lo", lo, 32'h0000_5678);
        runLongOp("divu0", OP_DIVU, 32'd77, 32'd0, 10, 32'h0000_5678);
        checkOutput("divu0_hi", hi, 32'h0000_1234);
        checkOutput("divu0_lo", lo, 32'h0000_5678);

        $display("[TB] mtlo issued during mult is ignored");
        applyStimulus(1'b1, OP_MULT, 32'hFFFF_FFFF, 32'd7, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                applyStimulus(1'b1, OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
            end else begin
                applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b1);
            end
            checkOutput("ign_busy", 32'(busy), 32'd1);
            checkOutput("ign_stall", 32'(stall_md), 32'd1);
            if (i == 2) begin
                checkOutput("ign_lo_hold", lo, 32'h0000_5678);
            end
            tick();
        end
        applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b1);
        checkOutput("ign_busy_done", 32'(busy), 32'd0);
        checkOutput("ign_stall_done", 32'(stall_md), 32'd0);
        checkOutput("ign_hi", hi, 32'hFFFF_FFFF);
        checkOutput("ign_lo", lo, 32'hFFFF_FFF9);
        tick();
        checkOutput("ign_lo_after", lo, 32'hFFFF_FFF9);

        $display("[TB] reset aborts div");
        applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            checkOutput("abort_no_commit_lo", lo, 32'd0);
            checkOutput("abort_no_commit_hi", hi, 32'd0);
            checkOutput("abort_no_busy", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
